remote_comm: RTL
================

Name: remote_comm

Overview:
- Bench/remote-side command transmitter and response receiver for the Knight's Tour system. It sits directly upstream of the Knight's Tour UART command input.
- Accepts a 16-bit command word and serialises it as two 8N1 UART frames, high byte first.
- Receives the single-byte response from the Knight (0xA5 on completion, 0x5A at intermediate stages) and holds it until the response is cleared.
- Contains its own baud-rate TX and RX engines, so there is no separate UART instance.

Parameters:
- BAUD_DIV, 5208, clocks per UART bit (50 MHz / 9600). Minimum 4.
- TMO_CLKS, 32'd50_000_000, response timeout in clocks; used only with RESP_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- send_cmd  in  1  request to transmit `cmd`; sampled only in TX IDLE.
- cmd  in  16  command word; latched when `send_cmd` is accepted.
- cmd_snt  out  1  one-cycle pulse when both bytes have been fully sent.
- TX  out  1  UART serial out, idle high.
- RX  in  1  UART serial in, asynchronous.
- resp  out  8  last valid received byte.
- resp_rdy  out  1  high while `resp` holds an unread byte.
- clr_resp_rdy  in  1  clears `resp_rdy`.
- resp_tmo  out  1  response-timeout flag (see Optional Feature).

Behaviour:
- Reset values:
  - TX=1, cmd_snt=0, resp=8'h00, resp_rdy=0, resp_tmo=0.
  - TX FSM in IDLE, RX FSM in IDLE.
  - RX synchroniser flops reset to 1.
- Reset asserted mid-frame: both FSMs return to IDLE on the next edge and TX goes high. The partial frame is abandoned and no `cmd_snt` is produced.
- TX FSM states: IDLE, HIGH, LOW, DONE.
  - IDLE: on `send_cmd`=1, latch `cmd`, load shifter with {1, cmd[15:8], 0}, go to HIGH.
  - `send_cmd` outside IDLE is ignored; there is no queueing.
  - HIGH: shift LSB-first, 10 bits (start 0, data[0..7], stop 1), each bit held exactly BAUD_DIV clocks.
  - After the 10th bit, load {1, cmd[7:0], 0} and go to LOW, with no idle gap between frames.
  - LOW: same 10-bit sequence, then go to DONE.
  - DONE: `cmd_snt`=1 for exactly one cycle, then go to IDLE.
  - A new `send_cmd` is accepted in the cycle after DONE.
- TX timing:
  - If `send_cmd` is sampled at edge N, TX falls at edge N+1.
  - `cmd_snt` is high in the cycle beginning at edge N+1+20*BAUD_DIV.
  - Bit counter is 4 bits, baud counter is ceil(log2(BAUD_DIV)) bits; both are reset at every bit boundary.
- RX synchroniser: RX passes through a 2-flop synchroniser. A falling edge is detected on the synchronised signal.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge, load the baud counter with BAUD_DIV/2 and go to START.
  - START: at mid-bit, if the line is still 0, go to DATA. Otherwise it is a false start: return to IDLE with no output change.
  - DATA: sample 8 bits, each BAUD_DIV clocks apart at mid-bit, LSB-first into a shift register, then go to STOP.
  - STOP: sample at mid-bit.
    - Sample = 1: `resp` is loaded with the byte and `resp_rdy` is set, both on the same edge. Return to IDLE.
    - Sample = 0 (framing error): discard the byte; `resp` and `resp_rdy` are unchanged. Return to IDLE.
- `resp_rdy` handling:
  - Cleared by `clr_resp_rdy`=1.
  - A valid byte and `clr_resp_rdy` on the same edge: the byte wins, `resp_rdy` stays 1 and `resp` is updated.
  - A new valid byte while `resp_rdy` is already 1 overwrites `resp`; `resp_rdy` stays 1.
- TX and RX are fully independent. A response may arrive while a command is still being transmitted.

Optional Feature:
- Macro: REMOTE_COMM_RESP_TMO_EN.
- Defined:
  - A 32-bit counter starts at the `cmd_snt` pulse and counts while `resp_rdy`=0.
  - Reaching TMO_CLKS sets `resp_tmo` (sticky) and stops the counter.
  - A valid received byte or a new `send_cmd` acceptance clears both the counter and `resp_tmo`.
- Undefined: no counter is built and `resp_tmo` is tied to 0.

Test Plan (BAUD_DIV=16, TMO_CLKS=2000 for simulation):
- Reset, then `send_cmd` with cmd=16'h4022 (tour from x=2, y=2) -> TX carries frame 0x40 then frame 0x22, LSB-first with correct start/stop bits. `cmd_snt` is a single pulse exactly 321 clocks after the accepting edge; TX then idles high.
- `send_cmd` with cmd=16'h3001 (move north 1 square, fanfare), and a second `send_cmd` with cmd=16'h0000 pulsed 50 clocks later -> only 0x30, 0x01 are transmitted, with one `cmd_snt` pulse.
- Drive an RX frame of 8'hA5 -> `resp`=8'hA5 and `resp_rdy`=1 at the stop-bit mid-sample. Pulse `clr_resp_rdy` -> `resp_rdy`=0 and `resp` still 8'hA5.
- RX frame 8'h5A with stop bit 0 -> `resp`/`resp_rdy` unchanged. A 4-clock low glitch on RX -> no frame accepted. A following valid 8'h5A is then received correctly.
- Valid 8'hA5 whose stop-sample edge coincides with `clr_resp_rdy`=1 -> `resp_rdy`=1 and `resp`=8'hA5. Deassert `rst_n` mid-TX frame -> TX=1 and FSMs IDLE on the next edge, with no `cmd_snt`.
- With REMOTE_COMM_RESP_TMO_EN: after `cmd_snt` with no RX traffic -> `resp_tmo`=1 at 2000 clocks. A subsequent 8'hA5 -> `resp_tmo`=0. Without the macro, `resp_tmo` stays 0 throughout.

Source files
------------

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - two-frame UART command transmitter and single-byte response receiver
// Optional response timeout is built when REMOTE_COMM_RESP_TMO_EN is defined.
module remote_comm #(
  parameter int          BAUD_DIV = 5208,
  parameter logic [31:0] TMO_CLKS = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_cmd,
  input  logic [15:0] cmd,
  output logic        cmd_snt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic        resp_tmo
);
  localparam int            BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW, TX_DONE} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    cmd_lo_q, cmd_lo_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_q, cmd_snt_q, cmd_acc;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    cmd_lo_d   = cmd_lo_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    cmd_acc    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_cmd) begin
          cmd_acc    = 1'b1;
          tx_sh_d    = {1'b1, cmd[15:8], 1'b0};
          cmd_lo_d   = cmd[7:0];
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_HIGH;
        end
      end
      TX_HIGH, TX_LOW: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            // Low-byte frame follows the high-byte stop bit with no idle gap.
            if (tx_state_q == TX_HIGH) begin
              tx_sh_d    = {1'b1, cmd_lo_q, 1'b0};
              tx_state_d = TX_LOW;
            end else begin
              tx_state_d = TX_DONE;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          end
        end else begin
          tx_baud_d = tx_baud_q + BW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '1;
      cmd_lo_q   <= '0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      cmd_snt_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      cmd_lo_q   <= cmd_lo_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= (tx_state_q == TX_HIGH || tx_state_q == TX_LOW) ? tx_sh_q[0] : 1'b1;
      cmd_snt_q  <= (tx_state_q == TX_DONE);
    end
  end

  assign TX      = tx_q;
  assign cmd_snt = cmd_snt_q;

  rx_state_e     rx_state_q, rx_state_d;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [BW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    resp_q, resp_d;
  logic          resp_rdy_q, resp_rdy_d;
  logic          rx_valid, rx_fall, rx_mid;

  // rx_s3_q is the previous synchronised level, used only for edge detection.
  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_mid  = (rx_baud_q == '0);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid   = 1'b0;
    if (rx_state_q != RX_IDLE) begin
      rx_baud_d = rx_mid ? BAUD_LAST : rx_baud_q - BW'(1);
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_baud_d  = BAUD_HALF;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_mid) begin
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_mid) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (rx_mid) begin
          rx_valid   = rx_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
    endcase
    resp_d     = rx_valid ? rx_sh_q : resp_q;
    resp_rdy_d = rx_valid | (resp_rdy_q & ~clr_resp_rdy);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

`ifdef REMOTE_COMM_RESP_TMO_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_run_q, tmo_run_d, resp_tmo_q, resp_tmo_d;

  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_run_d  = tmo_run_q;
    resp_tmo_d = resp_tmo_q;
    if (rx_valid || cmd_acc) begin
      tmo_cnt_d  = '0;
      tmo_run_d  = 1'b0;
      resp_tmo_d = 1'b0;
    end else if (cmd_snt_q) begin
      tmo_cnt_d = '0;
      tmo_run_d = 1'b1;
    end else if (tmo_run_q && !resp_rdy_q) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
      if (tmo_cnt_d == TMO_CLKS) begin
        resp_tmo_d = 1'b1;
        tmo_run_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q  <= '0;
      tmo_run_q  <= 1'b0;
      resp_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_run_q  <= tmo_run_d;
      resp_tmo_q <= resp_tmo_d;
    end
  end

  assign resp_tmo = resp_tmo_q;
`else
  assign resp_tmo = 1'b0;
`endif

endmodule
